// File: rtl/alu_operand_loader.sv
// alu_operand_loader: button-driven A / B / OpCode entry front end for the 8-bit ALU lab top.
// Define LOADER_DEBOUNCE_EN to build the per-button debounce counters; otherwise buttons are only synchronized.
module alu_operand_loader #(
  parameter int M               = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_next,
  input  logic         btn_back,
  input  logic [M-1:0] sw,
  input  logic [M-1:0] result,
  input  logic [3:0]   status,
  output logic [M-1:0] A,
  output logic [M-1:0] B,
  output logic [1:0]   OpCode,
  output logic         ops_valid,
  output logic [M-1:0] disp_value,
  output logic [3:0]   disp_status,
  output logic [3:0]   state_led
);

  // One-hot encoding doubles as the LED pattern.
  typedef enum logic [3:0] {
    WAIT_A  = 4'b0001,
    WAIT_B  = 4'b0010,
    WAIT_OP = 4'b0100,
    SHOW    = 4'b1000
  } state_e;

  // Button index 0 is next, index 1 is back.
  localparam int NB = 2;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] acc;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] pulse_q, pulse_d;
  logic          next_p, back_p;

  assign btn_raw = {btn_back, btn_next};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= acc;
      pulse_q <= pulse_d;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NB-1:0]            acc_q, acc_d;

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          acc_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`else
  assign acc = sync2_q;
`endif

  always_comb begin
    pulse_d = acc & ~prev_q;
  end

  assign next_p = pulse_q[0];
  assign back_p = pulse_q[1];

  state_e       state_q, state_d;
  logic [M-1:0] a_q, a_d;
  logic [M-1:0] b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic         valid_q, valid_d;
  logic [3:0]   disp_status_q, disp_status_d;
  logic [3:0]   state_led_q, state_led_d;
  logic         fwd, bwd;

  // Coincident next/back pulses cancel each other.
  assign fwd = next_p & ~back_p;
  assign bwd = back_p & ~next_p;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    case (state_q)
      WAIT_A: begin
        if (fwd) begin
          a_d     = sw;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (fwd) begin
          b_d     = sw;
          state_d = WAIT_OP;
        end else if (bwd) begin
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (fwd) begin
          op_d    = sw[1:0];
          valid_d = 1'b1;
          state_d = SHOW;
        end else if (bwd) begin
          state_d = WAIT_B;
        end
      end
      SHOW: begin
        if (fwd) begin
          valid_d = 1'b0;
          state_d = WAIT_A;
        end else if (bwd) begin
          valid_d = 1'b0;
          state_d = WAIT_OP;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = WAIT_A;
      end
    endcase
    state_led_d   = state_d;
    disp_status_d = (state_d == SHOW) ? status : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_A;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      valid_q       <= 1'b0;
      disp_status_q <= '0;
      state_led_q   <= WAIT_A;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      valid_q       <= valid_d;
      disp_status_q <= disp_status_d;
      state_led_q   <= state_led_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign OpCode      = op_q;
  assign ops_valid   = valid_q;
  assign disp_status = disp_status_q;
  assign state_led   = state_led_q;
  assign disp_value  = (state_q == SHOW) ? result : sw;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed vector table, timing corner cases, random model check.
module tb_alu_operand_loader;

  localparam int DEB = 4;
`ifdef LOADER_DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next, btn_back;
  logic [7:0] sw, result;
  logic [3:0] status;
  logic [7:0] A, B, disp_value;
  logic [1:0] OpCode;
  logic       ops_valid;
  logic [3:0] disp_status, state_led;

  int n_tests = 0;
  int n_fail  = 0;

  alu_operand_loader #(.M(8), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_back(btn_back),
    .sw(sw), .result(result), .status(status),
    .A(A), .B(B), .OpCode(OpCode), .ops_valid(ops_valid),
    .disp_value(disp_value), .disp_status(disp_status), .state_led(state_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       nxt;
    logic       bck;
    logic [7:0] sw;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       valid;
    logic [3:0] led;
  } vec_t;

  vec_t vecs[11];

  // Reference model: entry step index 0..3 = A, B, OpCode, SHOW.
  int         m_step;
  logic [7:0] m_a, m_b;
  logic [1:0] m_op;
  logic       m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_next = 1'b0;
    btn_back = 1'b0;
    reset    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    m_step = 0; m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0;
  endtask

  // Hold long enough for one accepted press, then release and let the release settle.
  task automatic press(input logic n, input logic b, input logic [7:0] s);
    sw       = s;
    btn_next = n;
    btn_back = b;
    repeat (LAT + 3) tick();
    btn_next = 1'b0;
    btn_back = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  task automatic model_step(input logic n, input logic b, input logic [7:0] s);
    if (n && !b) begin
      case (m_step)
        0: m_a = s;
        1: m_b = s;
        2: begin m_op = s[1:0]; m_valid = 1'b1; end
        default: m_valid = 1'b0;
      endcase
      m_step = (m_step + 1) % 4;
    end else if (b && !n) begin
      if (m_step == 3) m_valid = 1'b0;
      if (m_step > 0) m_step = m_step - 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".A"},      32'(A),           32'(m_a));
    check({tag, ".B"},      32'(B),           32'(m_b));
    check({tag, ".op"},     32'(OpCode),      32'(m_op));
    check({tag, ".valid"},  32'(ops_valid),   32'(m_valid));
    check({tag, ".led"},    32'(state_led),   32'(1 << m_step));
    check({tag, ".disp"},   32'(disp_value),  32'((m_step == 3) ? result : sw));
    check({tag, ".dstat"},  32'(disp_status), 32'((m_step == 3) ? status : 4'b0000));
  endtask

  // Edges from the current sample point until state_led leaves from_led.
  task automatic measure(input logic [3:0] from_led, output int edges);
    edges = 0;
    while (state_led == from_led && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;
    vecs[0]  = '{1'b1, 1'b0, 8'h12, 8'h12, 8'h00, 2'd0, 1'b0, 4'b0010};
    vecs[1]  = '{1'b1, 1'b0, 8'h34, 8'h12, 8'h34, 2'd0, 1'b0, 4'b0100};
    vecs[2]  = '{1'b1, 1'b0, 8'h02, 8'h12, 8'h34, 2'd2, 1'b1, 4'b1000};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h12, 8'h34, 2'd2, 1'b0, 4'b0100};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h12, 8'h34, 2'd2, 1'b0, 4'b0010};
    vecs[5]  = '{1'b1, 1'b1, 8'h99, 8'h12, 8'h34, 2'd2, 1'b0, 4'b0010};
    vecs[6]  = '{1'b1, 1'b0, 8'h56, 8'h12, 8'h56, 2'd2, 1'b0, 4'b0100};
    vecs[7]  = '{1'b1, 1'b0, 8'hFF, 8'h12, 8'h56, 2'd3, 1'b1, 4'b1000};
    vecs[8]  = '{1'b1, 1'b0, 8'h77, 8'h12, 8'h56, 2'd3, 1'b0, 4'b0001};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h12, 8'h56, 2'd3, 1'b0, 4'b0001};
    vecs[10] = '{1'b1, 1'b0, 8'hAB, 8'hAB, 8'h56, 2'd3, 1'b0, 4'b0010};

    sw = 8'h3C; result = 8'h46; status = 4'b0000;
    btn_next = 1'b0; btn_back = 1'b0; reset = 1'b1;
    repeat (3) tick();
    check("rst.A",     32'(A),           32'h0);
    check("rst.B",     32'(B),           32'h0);
    check("rst.op",    32'(OpCode),      32'h0);
    check("rst.valid", 32'(ops_valid),   32'h0);
    check("rst.led",   32'(state_led),   32'h1);
    check("rst.disp",  32'(disp_value),  32'h3C);
    check("rst.dstat", 32'(disp_status), 32'h0);
    do_reset();
    check("idle.led",  32'(state_led),  32'h1);
    check("idle.disp", 32'(disp_value), 32'h3C);

    // Press-to-state latency: pulse LAT edges after the press, state one edge later.
    sw = 8'hA5;
    btn_next = 1'b1;
    measure(4'b0001, edges);
    check("lat.edges", 32'(edges),     32'(LAT + 1));
    check("lat.led",   32'(state_led), 32'b0010);
    check("lat.A",     32'(A),         32'hA5);
    repeat (20) tick();
    check("hold.led",  32'(state_led), 32'b0010);
    btn_next = 1'b0;
    repeat (LAT + 3) tick();
    check("rel.led",   32'(state_led), 32'b0010);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      press(vecs[i].nxt, vecs[i].bck, vecs[i].sw);
      check($sformatf("vec%0d.A", i),     32'(A),          32'(vecs[i].a));
      check($sformatf("vec%0d.B", i),     32'(B),          32'(vecs[i].b));
      check($sformatf("vec%0d.op", i),    32'(OpCode),     32'(vecs[i].op));
      check($sformatf("vec%0d.valid", i), 32'(ops_valid),  32'(vecs[i].valid));
      check($sformatf("vec%0d.led", i),   32'(state_led),  32'(vecs[i].led));
      check($sformatf("vec%0d.disp", i),  32'(disp_value),
            32'((vecs[i].led == 4'b1000) ? 8'h46 : vecs[i].sw));
    end

`ifdef LOADER_DEBOUNCE_EN
    // Bouncing contact: toggles every 2 cycles must be rejected, then a steady hold is accepted once.
    do_reset();
    sw = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      btn_next = 1'b1; tick(); tick();
      btn_next = 1'b0; tick(); tick();
    end
    check("bounce.led", 32'(state_led), 32'b0001);
    btn_next = 1'b1;
    measure(4'b0001, edges);
    check("bounce.edges", 32'(edges),     32'(LAT + 1));
    check("bounce.A",     32'(A),         32'h5A);
    repeat (20) tick();
    check("bounce.once",  32'(state_led), 32'b0010);
    btn_next = 1'b0;
    repeat (LAT + 3) tick();
    sw = 8'h11;
    btn_next = 1'b1; tick();
    btn_next = 1'b0;
    repeat (20) tick();
    check("glitch.led", 32'(state_led), 32'b0010);
    check("glitch.B",   32'(B),         32'h00);
`endif

    // Asynchronous reset mid-debounce while in WAIT_OP.
    do_reset();
    result = 8'hC3; status = 4'b1010;
    press(1'b1, 1'b0, 8'h12);
    press(1'b1, 1'b0, 8'h34);
    check("pre.led", 32'(state_led), 32'b0100);
    sw = 8'h03;
    btn_next = 1'b1;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("async.A",     32'(A),           32'h0);
    check("async.B",     32'(B),           32'h0);
    check("async.valid", 32'(ops_valid),   32'h0);
    check("async.led",   32'(state_led),   32'b0001);
    check("async.disp",  32'(disp_value),  32'h03);
    btn_next = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (LAT + 6) tick();
    check("post.led",   32'(state_led), 32'b0001);
    check("post.valid", 32'(ops_valid), 32'h0);

    // Random presses against the model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int   r;
      logic n, b;
      logic [7:0] s;
      r = int'($urandom_range(0, 9));
      n = (r == 0) || (r > 3);
      b = (r <= 3);
      s = 8'($urandom);
      result = 8'($urandom);
      status = 4'($urandom);
      press(n, b, s);
      model_step(n, b, s);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Sequential operand-entry front end for the 8-bit ALU lab top.
- The user enters A, B and OpCode one at a time on the switches and confirms each with a button; the block registers them and drives the ALU inputs.
- It also selects what the 7-segment driver shows: the live switch value during entry, the ALU result once all operands are loaded.
- Sits between the board buttons/switches and ALU_comb / the display driver.

Parameters:
- M, 8, operand and result width in bits.
- DEBOUNCE_CYCLES, 1_000_000, clock cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- btn_next  input  1  raw confirm button (BTNC).
- btn_back  input  1  raw step-back button (BTNU).
- sw  input  M  raw switch value to capture.
- result  input  M  ALU result.
- status  input  4  ALU flags {N,Z,C,V}.
- A  output  M  registered operand A.
- B  output  M  registered operand B.
- OpCode  output  2  registered ALU opcode.
- ops_valid  output  1  high while A, B and OpCode form a complete, confirmed set.
- disp_value  output  M  value for the 7-segment driver.
- disp_status  output  4  flags for the LEDs.
- state_led  output  4  one-hot state indicator {SHOW, WAIT_OP, WAIT_B, WAIT_A}.

Behaviour:
- Reset (asynchronous assert, synchronous release on clk):
  - A, B, OpCode, disp_status = 0; ops_valid = 0.
  - State = WAIT_A, so state_led = 4'b0001.
  - disp_value = sw as a pass-through, unregistered.
  - All synchronizer, debounce and edge registers cleared.
  - A reset mid-debounce or mid-entry discards all progress.
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter: increments while the synchronized level differs from the accepted level; clears when they match. On reaching DEBOUNCE_CYCLES-1 the accepted level is updated and the counter cleared.
  - Rising-edge detect on the accepted level gives a 1-cycle pulse (next_p, back_p).
  - Latency from a stable raw press to the pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Holding a button produces exactly one pulse; release produces none.
- FSM transitions on next_p:
  - WAIT_A: A <= sw; go to WAIT_B.
  - WAIT_B: B <= sw; go to WAIT_OP.
  - WAIT_OP: OpCode <= sw[1:0]; ops_valid <= 1; go to SHOW.
  - SHOW: ops_valid <= 0; go to WAIT_A. A, B and OpCode are retained until overwritten.
- FSM transitions on back_p:
  - WAIT_A: no change.
  - WAIT_B: go to WAIT_A.
  - WAIT_OP: go to WAIT_B.
  - SHOW: ops_valid <= 0; go to WAIT_OP.
  - Registers are not modified on back_p.
- next_p and back_p in the same cycle: both ignored; state and registers unchanged.
- Outputs by state:
  - disp_value = result in SHOW, else sw (combinational mux).
  - disp_status = status registered each cycle in SHOW, 0 otherwise.
  - state_led is registered and one-hot; it never shows an illegal encoding.
  - Unreachable FSM encodings recover to WAIT_A.
- Width rules:
  - Captures are straight M-bit copies.
  - OpCode takes only sw[1:0]; upper switch bits are ignored in WAIT_OP.

Optional Feature:
- Macro: LOADER_DEBOUNCE_EN.
- Defined: full debounce counter as specified above.
- Undefined: the counter is removed; the accepted level equals the synchronized level. Pulse latency becomes 3 cycles and DEBOUNCE_CYCLES is unused. Used for fast simulation and for inputs already debounced upstream.
- Every other behaviour is identical in both builds.

Test Plan:
- Directed scenarios use DEBOUNCE_CYCLES=4 with the macro defined.
- Reset then idle: A=B=0, OpCode=0, ops_valid=0, state_led=0001; with sw=8'h3C, disp_value=8'h3C.
- Full entry:
  - sw=8'h12 + next, then sw=8'h34 + next, then sw=8'h02 + next.
  - Required: A=8'h12, B=8'h34, OpCode=2'b10, ops_valid=1, state_led=1000.
  - With result=8'h46 and status=4'b0000, disp_value=8'h46.
- Bounce rejection:
  - btn_next toggling every 2 cycles for 20 cycles, then held high: exactly one next_p, and only after 4 stable cycles.
  - A single-cycle glitch produces no state change.
- Back navigation:
  - From SHOW, back gives WAIT_OP, ops_valid=0; back again gives WAIT_B.
  - A and B remain 8'h12/8'h34; a further next with sw=8'h56 gives B=8'h56, state WAIT_OP.
- Simultaneous press: next and back pulses aligned in WAIT_B: state stays WAIT_B, B unchanged.
- Reset mid-operation:
  - Assert reset asynchronously (between clk edges) while in WAIT_OP with a debounce count in progress: all outputs return to reset values immediately.
  - No spurious pulse after release.
  - Repeat the full entry with the macro undefined: pulses arrive 3 cycles after each press.
